mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipelined memory stage for the RV64 core, replacing the combinational load/store pass-through between execute and writeback. It accepts one execute-stage instruction at a time over a valid/ready handshake. For loads and stores it issues an aligned, byte-strobed request on the data bus and holds it until the bus responds. It then extracts and sign- or zero-extends load data and presents a registered result to writeback, with stall, flush and misalignment handling.

## Interface
- XLEN, 64, datapath/address width (32 or 64)
- NBYTES, XLEN/8, bus bytes; OFFW = log2(NBYTES)

- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard in-flight instruction (pipeline redirect)
- in_valid / in_ready  in / out  1 / 1  execute handshake
- in_pc, in_result, in_wdata  in  XLEN each  PC; ALU result (effective address for memory ops); store data
- in_memread, in_memwrite, in_unsigned, in_regwrite  in  1 each  op controls
- in_size  in  2  0=byte 1=half 2=word 3=dword
- in_dst  in  5  destination register
- dreq_valid, dreq_write  out  1 each  bus request; write enable
- dreq_addr  out  XLEN  request address, NBYTES-aligned
- dreq_strobe  out  NBYTES  byte enables
- dreq_data  out  XLEN  lane-shifted store data
- dresp_ok  in  1  bus response, one-cycle pulse
- dresp_data  in  XLEN  raw aligned read data
- out_valid / out_ready  out / in  1 / 1  writeback handshake
- out_pc, out_regdata, out_addr  out  XLEN each  PC; writeback value; in_result copy
- out_regwrite, out_skip, out_misalign  out  1 each  regwrite (forced 0 on misalign); memread|memwrite; misaligned flag
- out_dst  out  5  destination register

## Operation
- Single output register (OR) plus FSM: IDLE, ACCESS, HOLD, DRAIN.
- Accept condition: in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- Misaligned: (memread|memwrite) && in_result mod 2^in_size != 0. in_size=3 with XLEN=32 is also misaligned.
- Non-memory or misaligned accept: OR is loaded directly. regdata = in_result; misaligned → out_misalign=1, out_regwrite=0. No bus access. State stays IDLE.
- Memory accept: latch the request and go to ACCESS.
  - off = addr[OFFW-1:0]; dreq_addr = addr with low OFFW bits cleared.
  - dreq_strobe = ((1<<2^size)-1) << off.
  - dreq_data = in_wdata << 8·off.
- ACCESS: dreq_valid=1 with all dreq_* fields stable until dresp_ok.
  - On dresp_ok, data = dresp_data >> 8·off, truncated to 2^size bytes, then sign-extended (zero-extended if in_unsigned). Stores produce regdata = in_result.
  - If the OR slot is free (!out_valid || out_ready): write OR, go to IDLE. Otherwise capture the result in the hold buffer and go to HOLD.
- HOLD: write OR from the hold buffer when the slot is free, then go to IDLE.
- flush, highest priority:
  - out_valid cleared next cycle.
  - IDLE: no effect beyond that.
  - ACCESS: go to DRAIN. dreq_valid stays 1 until dresp_ok; the response is discarded, then go to IDLE.
  - HOLD: buffer dropped, go to IDLE.
  - DRAIN + flush: stay in DRAIN.
- A bus request, once raised, is never withdrawn or altered before dresp_ok.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0: out_valid, dreq_valid, dreq_*, out_*. in_ready = 1 after release.
- Non-memory latency: accept in cycle 0 → out_valid in cycle 1.
- Memory latency: accept in cycle 0 → dreq_valid in cycle 1 → dresp_ok in cycle k → out_valid in cycle k+1 (slot free). With a zero-wait bus (k=1), latency is 2.
- Throughput: one non-memory op per cycle while out_ready=1. No new accept while in ACCESS, HOLD or DRAIN.
- out_* fields stable while out_valid && !out_ready.
- dresp_ok outside ACCESS/DRAIN is ignored.

## Test plan
- ALU op, in_result=0x1234, out_ready=1 → out_valid next cycle, regdata=0x1234, out_skip=0. Back-to-back ops sustain 1/cycle.
- lb at 0x8000_0003, dresp_data=0x0000_0000_80FF_0000 → dreq_addr=0x8000_0000, strobe=0x08, regdata=0xFFFF_FFFF_FFFF_FF80. Same access as lbu → 0x80.
- sh at 0x1006, wdata=0xABCD → strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_write=1, held 3 cycles until dresp_ok; out_skip=1.
- lw at 0x1002 → out_misalign=1, out_regwrite=0, dreq_valid never asserted.
- ld in flight with out_ready=0 when dresp_ok arrives → HOLD. Result appears once out_ready=1; in_ready stays 0 until then.
- flush during ACCESS → dreq_valid held until dresp_ok, no out_valid. resetn pulsed mid-ACCESS → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Memory stage between execute and writeback. Issues aligned,
//             byte-strobed bus requests for loads/stores, extracts and
//             extends load data, and presents a registered writeback result
//             with stall, flush and misalignment handling.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  // execute-side handshake
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_unsigned,
  input  logic              in_regwrite,
  input  logic [1:0]        in_size,
  input  logic [4:0]        in_dst,
  // data bus
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [NBYTES-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_ok,
  input  logic [XLEN-1:0]   dresp_data,
  // writeback-side handshake
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_regdata,
  output logic [XLEN-1:0]   out_addr,
  output logic              out_regwrite,
  output logic              out_skip,
  output logic              out_misalign,
  output logic [4:0]        out_dst
);

  localparam int OFFW     = $clog2(NBYTES);
  localparam bit DWORD_OK = (XLEN >= 64);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              state_q;

  // bus request registers
  logic                dreq_valid_q;
  logic                dreq_write_q;
  logic [XLEN-1:0]     dreq_addr_q;
  logic [NBYTES-1:0]   dreq_strobe_q;
  logic [XLEN-1:0]     dreq_data_q;

  // in-flight memory instruction context
  logic [OFFW-1:0]     off_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic                memread_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     result_q;
  logic                regwrite_q;
  logic [4:0]          dst_q;
  logic [XLEN-1:0]     hold_q;

  // output register
  logic                out_valid_q;
  logic [XLEN-1:0]     out_pc_q;
  logic [XLEN-1:0]     out_regdata_q;
  logic [XLEN-1:0]     out_addr_q;
  logic                out_regwrite_q;
  logic                out_skip_q;
  logic                out_misalign_q;
  logic [4:0]          out_dst_q;

  logic                w_slot_free;
  logic                w_accept;
  logic                w_is_mem;
  logic [2:0]          w_low_mask;
  logic                w_misalign;
  logic [OFFW-1:0]     w_off;
  logic [NBYTES-1:0]   w_strobe;
  logic [XLEN-1:0]     w_req_addr;
  logic [XLEN-1:0]     w_req_data;
  logic [XLEN-1:0]     w_rsh;
  logic                w_sign;
  logic [XLEN-1:0]     w_load;
  logic [XLEN-1:0]     w_resp_data;

  // Handshake and alignment decode for the incoming instruction
  always_comb begin
    w_slot_free = !out_valid_q || out_ready;
    in_ready    = (state_q == S_IDLE) && !flush && w_slot_free;
    w_accept    = in_valid && in_ready;
    w_is_mem    = in_memread || in_memwrite;
    case (in_size)
      2'd0:    w_low_mask = 3'b000;
      2'd1:    w_low_mask = 3'b001;
      2'd2:    w_low_mask = 3'b011;
      default: w_low_mask = 3'b111;
    endcase
    w_misalign = w_is_mem &&
                 (((in_result[2:0] & w_low_mask) != 3'b000) ||
                  ((in_size == 2'd3) && !DWORD_OK));
    w_off      = in_result[OFFW-1:0];
    w_req_addr = {in_result[XLEN-1:OFFW], {OFFW{1'b0}}};
    w_req_data = in_wdata << {w_off, 3'b000};
  end

  // Byte strobe: 2^size contiguous lanes starting at the byte offset
  always_comb begin
    w_strobe = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_strobe[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << in_size));
    end
  end

  // Load extraction: shift lane down, keep 2^size bytes, sign/zero-extend
  always_comb begin
    w_rsh = dresp_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    w_sign = w_rsh[7];
      2'd1:    w_sign = w_rsh[15];
      2'd2:    w_sign = w_rsh[31];
      default: w_sign = w_rsh[XLEN-1];
    endcase
    w_load = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_load[i] = (i < (8 << size_q)) ? w_rsh[i] : (w_sign && !unsigned_q);
    end
    // stores write back the ALU result unchanged
    w_resp_data = memread_q ? w_load : result_q;
  end

  // Stage FSM with registered bus request and output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      dreq_valid_q   <= 1'b0;
      dreq_write_q   <= 1'b0;
      dreq_addr_q    <= '0;
      dreq_strobe_q  <= '0;
      dreq_data_q    <= '0;
      off_q          <= '0;
      size_q         <= 2'd0;
      unsigned_q     <= 1'b0;
      memread_q      <= 1'b0;
      pc_q           <= '0;
      result_q       <= '0;
      regwrite_q     <= 1'b0;
      dst_q          <= 5'd0;
      hold_q         <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_regdata_q  <= '0;
      out_addr_q     <= '0;
      out_regwrite_q <= 1'b0;
      out_skip_q     <= 1'b0;
      out_misalign_q <= 1'b0;
      out_dst_q      <= 5'd0;
    end else begin
      // writeback consumed the current result
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mem && !w_misalign) begin
              pc_q          <= in_pc;
              result_q      <= in_result;
              regwrite_q    <= in_regwrite;
              dst_q         <= in_dst;
              off_q         <= w_off;
              size_q        <= in_size;
              unsigned_q    <= in_unsigned;
              memread_q     <= in_memread;
              dreq_valid_q  <= 1'b1;
              dreq_write_q  <= in_memwrite;
              dreq_addr_q   <= w_req_addr;
              dreq_strobe_q <= w_strobe;
              dreq_data_q   <= w_req_data;
              state_q       <= S_ACCESS;
            end else begin
              out_valid_q    <= 1'b1;
              out_pc_q       <= in_pc;
              out_regdata_q  <= in_result;
              out_addr_q     <= in_result;
              out_regwrite_q <= in_regwrite && !w_misalign;
              out_skip_q     <= w_is_mem;
              out_misalign_q <= w_misalign;
              out_dst_q      <= in_dst;
            end
          end
        end

        S_ACCESS: begin
          if (dresp_ok) begin
            dreq_valid_q <= 1'b0;
            if (flush) begin
              // response coincides with the redirect: bus is done, drop it
              state_q <= S_IDLE;
            end else if (w_slot_free) begin
              out_valid_q    <= 1'b1;
              out_pc_q       <= pc_q;
              out_regdata_q  <= w_resp_data;
              out_addr_q     <= result_q;
              out_regwrite_q <= regwrite_q;
              out_skip_q     <= 1'b1;
              out_misalign_q <= 1'b0;
              out_dst_q      <= dst_q;
              state_q        <= S_IDLE;
            end else begin
              hold_q  <= w_resp_data;
              state_q <= S_HOLD;
            end
          end else if (flush) begin
            // request must stay up until the bus answers
            state_q <= S_DRAIN;
          end
        end

        S_HOLD: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (w_slot_free) begin
            out_valid_q    <= 1'b1;
            out_pc_q       <= pc_q;
            out_regdata_q  <= hold_q;
            out_addr_q     <= result_q;
            out_regwrite_q <= regwrite_q;
            out_skip_q     <= 1'b1;
            out_misalign_q <= 1'b0;
            out_dst_q      <= dst_q;
            state_q        <= S_IDLE;
          end
        end

        default: begin
          // S_DRAIN: wait out the response of a flushed access and discard it
          if (dresp_ok) begin
            dreq_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
      endcase

      // a redirect always empties the output register
      if (flush) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign dreq_valid   = dreq_valid_q;
  assign dreq_write   = dreq_write_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_regdata  = out_regdata_q;
  assign out_addr     = out_addr_q;
  assign out_regwrite = out_regwrite_q;
  assign out_skip     = out_skip_q;
  assign out_misalign = out_misalign_q;
  assign out_dst      = out_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Self-checking bench for mem_access_stage (XLEN=64): directed
//             scenarios plus randomized traffic against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready;
  logic [63:0] in_pc, in_result, in_wdata;
  logic        in_memread, in_memwrite, in_unsigned, in_regwrite;
  logic [1:0]  in_size;
  logic [4:0]  in_dst;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr, dreq_data;
  logic [7:0]  dreq_strobe;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_regdata, out_addr;
  logic        out_regwrite, out_skip, out_misalign;
  logic [4:0]  out_dst;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_wdata(in_wdata),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_unsigned(in_unsigned), .in_regwrite(in_regwrite),
    .in_size(in_size), .in_dst(in_dst),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_regdata(out_regdata), .out_addr(out_addr),
    .out_regwrite(out_regwrite), .out_skip(out_skip),
    .out_misalign(out_misalign), .out_dst(out_dst)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] regdata;
    logic [63:0] addr;
    logic        regwrite;
    logic        skip;
    logic        mis;
    logic [4:0]  dst;
  } res_t;

  int checks = 0;
  int failures = 0;

  // model state
  res_t         expq[$];
  bit           mem_inflight = 0;
  res_t         cur;
  int           cur_off, cur_size;
  bit           cur_uns, cur_rd;
  bit           exp_req_v = 0;
  logic [136:0] exp_req;
  // bus responder state
  bit           bus_active = 0;
  int           bus_cnt = 0;
  logic [136:0] bus_snap;
  logic [63:0]  bus_data;
  int           bus_fixed_delay = -1;
  bit           bus_fixed_data_v = 0;
  logic [63:0]  bus_fixed_data = '0;
  bit           stray_en = 0;
  int           accepts = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t dut_out();
    return {out_pc, out_regdata, out_addr, out_regwrite, out_skip, out_misalign, out_dst};
  endfunction

  // architectural load result from raw bus word
  function automatic logic [63:0] ref_load(input logic [63:0] data, input int off,
                                           input int size, input bit uns);
    int nb;
    logic [63:0] v, mask;
    nb   = 8 * (1 << size);
    v    = data >> (8 * off);
    mask = (nb == 64) ? {64{1'b1}} : ((64'd1 << nb) - 64'd1);
    v    = v & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  // one clock: bus responder, pre-edge sampling, edge, model update
  task automatic tick();
    logic rdy, acc, ovh, fl, rsp, stall;
    res_t snap, e, r;
    logic [136:0] req_now;
    logic [63:0] c_pc, c_res, c_wd;
    logic c_rd, c_wr, c_uns, c_rw;
    logic [1:0] c_sz;
    logic [4:0] c_dst;
    int nb, off;
    req_now = {dreq_addr, dreq_strobe, dreq_data, dreq_write};
    if (dreq_valid && !bus_active) begin
      check_eq("req_expected", dreq_valid, exp_req_v);
      if (exp_req_v) check_eq("req_fields", req_now, exp_req);
      bus_active = 1;
      bus_snap   = req_now;
      bus_cnt    = (bus_fixed_delay >= 0) ? bus_fixed_delay : int'($urandom_range(0, 3));
      bus_data   = bus_fixed_data_v ? bus_fixed_data : {$urandom, $urandom};
    end else if (bus_active) begin
      check_eq("req_stable", {dreq_valid, req_now}, {1'b1, bus_snap});
    end else if (exp_req_v) begin
      check_eq("req_issued", dreq_valid, exp_req_v);
    end
    exp_req_v = 0;
    dresp_ok   = (bus_active && bus_cnt == 0) ||
                 (!bus_active && stray_en && $urandom_range(0, 7) == 0);
    dresp_data = bus_active ? bus_data : {$urandom, $urandom};
    #1;
    rdy   = in_ready;
    acc   = in_valid && rdy;
    ovh   = out_valid && out_ready && !flush;
    fl    = flush;
    rsp   = dresp_ok && bus_active;
    stall = out_valid && !out_ready && !flush;
    snap  = dut_out();
    c_pc = in_pc; c_res = in_result; c_wd = in_wdata; c_rd = in_memread;
    c_wr = in_memwrite; c_uns = in_unsigned; c_rw = in_regwrite; c_sz = in_size;
    c_dst = in_dst;
    if (mem_inflight || bus_active) check_eq("busy_in_ready", rdy, 1'b0);
    @(posedge clk);
    #1;
    if (stall) begin
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_stable", dut_out(), snap);
    end
    if (ovh) begin
      if (expq.size() == 0) check_eq("unexpected_out", ovh, 1'b0);
      else begin
        e = expq.pop_front();
        check_eq("out_record", snap, e);
      end
    end
    if (fl) begin
      expq.delete();
      mem_inflight = 0;
    end
    if (rsp) begin
      bus_active = 0;
      if (mem_inflight) begin
        if (cur_rd) cur.regdata = ref_load(bus_data, cur_off, cur_size, cur_uns);
        expq.push_back(cur);
        mem_inflight = 0;
      end
    end else if (bus_active) begin
      bus_cnt--;
    end
    if (acc) begin
      accepts++;
      nb  = 1 << c_sz;
      off = int'(c_res % 8);
      r.pc = c_pc; r.regdata = c_res; r.addr = c_res; r.dst = c_dst;
      r.skip = c_rd || c_wr;
      r.mis  = r.skip && ((c_res % nb) != 0);
      r.regwrite = c_rw && !r.mis;
      if (r.skip && !r.mis) begin
        mem_inflight = 1;
        cur = r; cur_off = off; cur_size = int'(c_sz); cur_uns = c_uns; cur_rd = c_rd;
        exp_req_v = 1;
        exp_req = {c_res - (c_res % 8), 8'(((1 << nb) - 1) << off), c_wd << (8 * off), c_wr};
      end else begin
        expq.push_back(r);
      end
    end
  endtask

  task automatic issue(input logic [63:0] pc, input logic [63:0] res, input logic [63:0] wd,
                       input bit rd, input bit wr, input bit uns, input logic [1:0] sz,
                       input logic [4:0] dst);
    in_valid = 1; in_pc = pc; in_result = res; in_wdata = wd; in_memread = rd;
    in_memwrite = wr; in_unsigned = uns; in_size = sz; in_dst = dst; in_regwrite = !wr;
    tick();
    in_valid = 0; in_memread = 0; in_memwrite = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0; flush = 0; out_ready = 1;
    while ((expq.size() != 0 || bus_active || mem_inflight || out_valid) && n < 60) begin
      tick();
      n++;
    end
    check_eq("drain_done", n < 60, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, n;
    resetn = 0; flush = 0; in_valid = 0; in_pc = '0; in_result = '0; in_wdata = '0;
    in_memread = 0; in_memwrite = 0; in_unsigned = 0; in_regwrite = 0; in_size = 2'd0;
    in_dst = 5'd0; dresp_ok = 0; dresp_data = '0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", {dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data}, '0);
    check_eq("rst_out", {out_valid, dut_out()}, '0);
    @(negedge clk) resetn = 1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);

    // ALU op, single-cycle latency, then back-to-back throughput
    a = accepts;
    issue(64'h100, 64'h1234, 64'h0, 0, 0, 0, 2'd3, 5'd1);
    check_eq("alu_accept", accepts, a + 1);
    check_eq("alu_valid", out_valid, 1'b1);
    check_eq("alu_regdata", out_regdata, 64'h1234);
    check_eq("alu_skip", out_skip, 1'b0);
    a = accepts;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_pc = 64'h200 + 64'(4 * i); in_result = 64'(i * 7 + 3);
      in_regwrite = 1; in_dst = 5'(i + 2);
      tick();
    end
    in_valid = 0;
    check_eq("b2b_accepts", accepts, a + 4);
    drain();

    // lb / lbu at 0x8000_0003 on a zero-wait bus
    bus_fixed_delay = 0; bus_fixed_data_v = 1; bus_fixed_data = 64'h0000_0000_80FF_0000;
    for (int u = 0; u < 2; u++) begin
      issue(64'h300, 64'h8000_0003, 64'h0, 1, 0, u[0], 2'd0, 5'd5);
      check_eq("lb_req_valid", dreq_valid, 1'b1);
      check_eq("lb_addr", dreq_addr, 64'h8000_0000);
      check_eq("lb_strobe", dreq_strobe, 8'h08);
      tick();
      check_eq("lb_valid_lat2", out_valid, 1'b1);
      check_eq("lb_regdata", out_regdata, (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
      tick();
    end

    // sh at 0x1006, response after three request cycles
    bus_fixed_delay = 2;
    issue(64'h400, 64'h1006, 64'hABCD, 0, 1, 0, 2'd1, 5'd0);
    check_eq("sh_strobe", dreq_strobe, 8'hC0);
    check_eq("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
    check_eq("sh_write", dreq_write, 1'b1);
    n = 0;
    while (dreq_valid && n < 10) begin tick(); n++; end
    check_eq("sh_req_cycles", n, 3);
    check_eq("sh_valid", out_valid, 1'b1);
    check_eq("sh_skip", out_skip, 1'b1);
    tick();

    // misaligned lw: no bus access
    issue(64'h500, 64'h1002, 64'h0, 1, 0, 0, 2'd2, 5'd7);
    check_eq("lw_mis", out_misalign, 1'b1);
    check_eq("lw_regwrite", out_regwrite, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lw_noreq", dreq_valid, 1'b0);
      tick();
    end

    // ld completes while writeback stalls
    bus_fixed_delay = 1; bus_fixed_data = 64'h0123_4567_89AB_CDEF;
    out_ready = 0;
    issue(64'h600, 64'h2008, 64'h0, 1, 0, 0, 2'd3, 5'd9);
    tick(); tick();
    a = accepts;
    in_valid = 1; in_result = 64'h55; in_regwrite = 1;
    for (int i = 0; i < 4; i++) begin
      check_eq("ld_stall_valid", out_valid, 1'b1);
      check_eq("ld_stall_data", out_regdata, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    in_valid = 0;
    check_eq("ld_stall_noaccept", accepts, a);
    drain();

    // flush during ACCESS: request held, response discarded
    bus_fixed_delay = 3;
    issue(64'h700, 64'h3000, 64'h0, 1, 0, 0, 2'd3, 5'd4);
    flush = 1;
    tick();
    flush = 0;
    n = 0;
    while (dreq_valid && n < 10) begin
      check_eq("flush_no_out", out_valid, 1'b0);
      tick();
      n++;
    end
    check_eq("flush_drain_cycles", n, 3);
    tick();
    check_eq("flush_after", out_valid, 1'b0);

    // randomized traffic
    bus_fixed_delay = -1; bus_fixed_data_v = 0; stray_en = 1;
    for (int c = 0; c < 800; c++) begin
      int kind;
      kind        = int'($urandom_range(0, 3));
      in_valid    = ($urandom_range(0, 2) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      in_pc       = {$urandom, $urandom};
      in_result   = {$urandom, $urandom};
      in_wdata    = {$urandom, $urandom};
      in_size     = 2'($urandom_range(0, 3));
      in_unsigned = $urandom_range(0, 1) != 0;
      in_regwrite = $urandom_range(0, 1) != 0;
      in_dst      = 5'($urandom);
      in_memread  = (kind == 2);
      in_memwrite = (kind == 3);
      if ($urandom_range(0, 1) != 0) in_result = in_result & ~64'(8'hFF >> (8 - (1 << in_size)));
      tick();
    end
    stray_en = 0;
    drain();

    // asynchronous reset in the middle of an access
    bus_fixed_delay = 5;
    issue(64'h800, 64'h4000, 64'h0, 1, 0, 0, 2'd3, 5'd3);
    tick();
    #2 resetn = 0;
    #1;
    check_eq("arst_req", {dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data}, '0);
    check_eq("arst_out", {out_valid, dut_out()}, '0);
    bus_active = 0; mem_inflight = 0; exp_req_v = 0; expq.delete(); dresp_ok = 0;
    @(negedge clk) resetn = 1;
    @(posedge clk);
    #1;
    check_eq("arst_in_ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
